spi_master_tx: RTL and testbench
================================

# spi_master_tx

Master-side SPI transmit and clock-generation stage: accepts words on an AXI-Stream slave port, drives `sclk`, `mosi` and `cs_n`, and supplies `enable_capture` to the `spi_rx` receiver alongside it. Together they form a full-duplex SPI master. `spi_master_tx` owns all bus timing. `spi_rx` samples MISO on the edges this block produces.

## Interface
Parameters:
- `AXIS_DATA_WIDTH`, 8: word container width; maximum 64.
- `PRESCALE_WIDTH`, 16: width of the `prescale` input.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `s_axis_tdata`  in  AXIS_DATA_WIDTH  word to transmit; the low `W` bits are used.
- `s_axis_tvalid`  in  1  AXIS valid.
- `s_axis_tready`  out  1  AXIS ready.
- `sclk`  out  1  SPI clock.
- `mosi`  out  1  serial data out, MSB first.
- `cs_n`  out  1  chip select, active-low.
- `enable_capture`  out  1  qualifies `spi_rx` sampling; high exactly while `cs_n` is low.
- `spi_mode`  in  2  CPOL = `spi_mode[1]`, CPHA = `spi_mode[0]`.
- `spi_word_width`  in  6  bits per word `W`.
- `prescale`  in  PRESCALE_WIDTH  half-period `H = prescale + 1` clk cycles.
- `busy`  out  1  high from word acceptance until GAP completes.

## Operation
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- **IDLE**
  - `s_axis_tready = 1`, `cs_n = 1`, `sclk = CPOL`.
  - On `tvalid && tready`: latch tdata, `spi_mode`, `W` and `H`, then go to SETUP.
  - Config inputs are ignored until the next IDLE.
- **Word width:** `spi_word_width` of 0 or greater than `AXIS_DATA_WIDTH` is clamped to `AXIS_DATA_WIDTH`.
- **SETUP**
  - `cs_n = 0`. `mosi` = bit `W-1` when CPHA=0; `mosi` keeps its previous value when CPHA=1.
  - Lasts `H` cycles, then go to SHIFT.
- **SHIFT**
  - `sclk` toggles every `H` cycles, giving `2W` edges total. An edge counter (7 bits) tracks them.
  - CPHA=0: `mosi` advances to the next bit on each trailing edge (even-numbered edges 2, 4, …), except after the last edge.
  - CPHA=1: `mosi` advances on each leading edge (odd edges 1, 3, …). The first leading edge presents bit `W-1`.
  - After edge `2W`, go to HOLD. `sclk` is back at CPOL.
- **HOLD:** `cs_n = 0` for `H` cycles, then go to GAP.
- **GAP:** `cs_n = 1` for `H` cycles, then go to IDLE. Back-to-back words are therefore always separated by at least `H+1` cycles of `cs_n` high.
- **`mosi` idle level:** returns to 1 on entry to GAP.
- **Width rule:** the shift register is `AXIS_DATA_WIDTH` wide and is left-aligned at load (`data << (AXIS_DATA_WIDTH-W)`). It always shifts out the MSB.

## Timing
- **Reset values (async, on `rst_n` low):**
  - state = IDLE
  - `s_axis_tready` = 0, rising 1 cycle after `rst_n` deasserts
  - `sclk` = 0
  - `mosi` = 1
  - `cs_n` = 1
  - `enable_capture` = 0
  - `busy` = 0
  - all counters = 0
- **Registered outputs:** all outputs are registered. `sclk`, `mosi` and `cs_n` must be glitch-free.
- **Handshake:**
  - `s_axis_tready` drops in the cycle after the handshake.
  - `cs_n` falls in that same cycle (latency 1).
- **Frame length:** `cs_n` stays low for `H·(2W+2)` cycles.
- **Turnaround:** `s_axis_tready` reasserts `H` cycles after `cs_n` rises.
- **`tvalid` without `tready`:** no effect. Data must stay stable per AXIS rules; the block does not check this.
- **Reset mid-frame:** all outputs go immediately to their reset values. `cs_n` rises asynchronously. The partial word is discarded and the next word restarts with SETUP.
- **`prescale = 0`:** `sclk` = clk/2. Every state still lasts at least one cycle.
- **`W = 1`:** two edges, then HOLD.

## Structure
- **Shared package `spi_pkg`:**
  - `spi_state_t` enum (IDLE/SETUP/SHIFT/HOLD/GAP)
  - functions `cpol(mode)` and `cpha(mode)`
  - the width-clamp function
  - `SPI_MAX_WIDTH = 64`
- **Sub-module `spi_clk_div`:**
  - Inputs: `clk`, `rst_n`, `load`, `H`.
  - Output: `tick`, asserted one cycle every `H` cycles while enabled.
  - Reloads on `load`. The FSM advances on `tick`.

## Test plan
- **Mode 0, W=8, prescale=1:** send 0xA5. Expect:
  - `cs_n` low for 36 cycles
  - 8 rising edges
  - `mosi` sampled at rising edges = 1,0,1,0,0,1,0,1
  - `enable_capture` matches `~cs_n`
- **Mode 3, W=8:** send 0x3C. Expect:
  - `sclk` idles high
  - `mosi` changes on falling edges
  - value sampled on rising edges = 0x3C
- **Mode 1, W=12, `AXIS_DATA_WIDTH=16`:** send 0x0ABC. Expect 12 bits sampled on falling edges = 0xABC.
- **Clamp:** `spi_word_width=0`, then `spi_word_width=63`, with `AXIS_DATA_WIDTH=8`. Expect 8 bits transferred in both cases.
- **Back-to-back:** `tvalid` held high with 0x01 then 0x80, `prescale=0`. Expect:
  - `cs_n` high for exactly 2 cycles between frames
  - second handshake 1 cycle after GAP ends
- **Reset mid-frame:** `rst_n` low during bit 3. Expect:
  - `cs_n=1`, `mosi=1`, `sclk=0` with no clock edge needed
  - `tready=1` one cycle after release
  - next word 0xFF transmitted intact

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and helpers for the SPI master transmit stage:
//                FSM state encoding, SPI mode decoding and word-width clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_MAX_WIDTH = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_t;

    // Clock polarity: idle level of sclk.
    function automatic logic cpol(input logic [1:0] mode);
        return mode[1];
    endfunction

    // Clock phase: 0 = sample on leading edge, 1 = sample on trailing edge.
    function automatic logic cpha(input logic [1:0] mode);
        return mode[0];
    endfunction

    // A requested width of 0, or one wider than the container, means "full container".
    function automatic logic [6:0] clamp_width(input logic [5:0] req, input int max_w);
        if (req == 6'd0 || int'(req) > max_w) begin
            return 7'(max_w);
        end
        return {1'b0, req};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_tx_clk_div.sv
`default_nettype none
// ============================================================================
//  Module      : spi_clk_div
//  Description : Half-period tick generator. While load is low, tick pulses
//                for one cycle every h cycles; load restarts the count.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_div #(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [PRESCALE_WIDTH:0] h,
    output logic                    tick
);

    logic [PRESCALE_WIDTH:0] r_cnt;
    logic [PRESCALE_WIDTH:0] w_last_cnt;
    logic                    w_last;

    assign w_last_cnt = h - {{PRESCALE_WIDTH{1'b0}}, 1'b1};
    assign w_last     = (r_cnt == w_last_cnt);
    assign tick       = w_last && !load;

    // Free-running count that wraps on every tick and restarts on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + {{PRESCALE_WIDTH{1'b0}}, 1'b1};
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master_tx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_tx
//  Description : SPI master transmit / bus-timing stage. Accepts words on an
//                AXI-Stream slave port and drives sclk, mosi, cs_n plus the
//                capture qualifier for the companion receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 8,
    parameter int PRESCALE_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic                       sclk,
    output logic                       mosi,
    output logic                       cs_n,
    output logic                       enable_capture,
    input  logic [1:0]                 spi_mode,
    input  logic [5:0]                 spi_word_width,
    input  logic [PRESCALE_WIDTH-1:0]  prescale,
    output logic                       busy
);

    localparam int c_aw = AXIS_DATA_WIDTH;

    spi_state_t                r_state;
    spi_state_t                w_next_state;
    logic [c_aw-1:0]           r_shreg;
    logic                      r_cpha;
    logic [6:0]                r_w;
    logic [PRESCALE_WIDTH:0]   r_h;
    logic [6:0]                r_edge_cnt;
    logic                      r_sclk;
    logic                      r_mosi;
    logic                      r_cs_n;
    logic                      r_en_cap;
    logic                      r_tready;
    logic                      r_busy;

    logic                      w_handshake;
    logic                      w_tick;
    logic [6:0]                w_width;
    logic [c_aw-1:0]           w_aligned;
    logic [PRESCALE_WIDTH:0]   w_h_in;
    logic                      w_last_edge;
    logic                      w_advance;
    logic                      w_next_idle;
    logic                      w_next_gap;

    assign w_handshake = s_axis_tvalid && r_tready;
    assign w_width     = clamp_width(spi_word_width, c_aw);
    // Left-align so the first bit out is always the container MSB.
    assign w_aligned   = s_axis_tdata << (c_aw - int'(w_width));
    assign w_h_in      = {1'b0, prescale} + {{PRESCALE_WIDTH{1'b0}}, 1'b1};
    // Edge 2W is the one taken when 2W-1 edges have already been counted.
    assign w_last_edge = (r_edge_cnt == ({r_w[5:0], 1'b0} - 7'd1));
    // The upcoming edge is odd (leading) when the count so far is even.
    assign w_advance   = r_cpha ? !r_edge_cnt[0] : (r_edge_cnt[0] && !w_last_edge);
    assign w_next_idle = (w_next_state == IDLE);
    assign w_next_gap  = (w_next_state == GAP);

    spi_clk_div #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_clk_div (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (r_state == IDLE),
        .h     (r_h),
        .tick  (w_tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: every non-idle state lasts whole half-periods.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_handshake)               w_next_state = SETUP;
            SETUP:   if (w_tick)                    w_next_state = SHIFT;
            SHIFT:   if (w_tick && w_last_edge)     w_next_state = HOLD;
            HOLD:    if (w_tick)                    w_next_state = GAP;
            GAP:     if (w_tick)                    w_next_state = IDLE;
            default:                                w_next_state = IDLE;
        endcase
    end

    // Registered bus outputs and shift datapath, all derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg    <= '0;
            r_cpha     <= 1'b0;
            r_w        <= '0;
            r_h        <= '0;
            r_edge_cnt <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b1;
            r_cs_n     <= 1'b1;
            r_en_cap   <= 1'b0;
            r_tready   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_tready <= w_next_idle;
            r_busy   <= !w_next_idle;
            r_cs_n   <= w_next_idle || w_next_gap;
            r_en_cap <= !(w_next_idle || w_next_gap);
            case (r_state)
                IDLE: begin
                    r_sclk     <= cpol(spi_mode);
                    r_edge_cnt <= '0;
                    if (w_handshake) begin
                        r_cpha <= cpha(spi_mode);
                        r_w    <= w_width;
                        r_h    <= w_h_in;
                        if (cpha(spi_mode)) begin
                            r_shreg <= w_aligned;
                        end else begin
                            // CPHA=0 presents the first bit before any clock edge.
                            r_mosi  <= w_aligned[c_aw-1];
                            r_shreg <= w_aligned << 1;
                        end
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        r_sclk     <= !r_sclk;
                        r_edge_cnt <= r_edge_cnt + 7'd1;
                        if (w_advance) begin
                            r_mosi  <= r_shreg[c_aw-1];
                            r_shreg <= r_shreg << 1;
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_mosi <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_axis_tready  = r_tready;
    assign sclk           = r_sclk;
    assign mosi           = r_mosi;
    assign cs_n           = r_cs_n;
    assign enable_capture = r_en_cap;
    assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_tx
//  Description : Self-checking bench for spi_master_tx (8- and 16-bit
//                containers). Words are queued as expected frames when the
//                handshake happens and compared as each cs_n frame closes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_tx;

    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    spi_mode;
    logic [5:0]    spi_word_width;
    logic [PW-1:0] prescale;

    logic [7:0]  tdata8;
    logic        tvalid8;
    logic        tready8, sclk8, mosi8, cs_n8, en8, busy8;
    logic [15:0] tdata16;
    logic        tvalid16;
    logic        tready16, sclk16, mosi16, cs_n16, en16, busy16;

    logic sel;

    always #5 clk = ~clk;

    spi_master_tx #(.AXIS_DATA_WIDTH(8), .PRESCALE_WIDTH(PW)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(tdata8), .s_axis_tvalid(tvalid8), .s_axis_tready(tready8),
        .sclk(sclk8), .mosi(mosi8), .cs_n(cs_n8), .enable_capture(en8),
        .spi_mode(spi_mode), .spi_word_width(spi_word_width), .prescale(prescale),
        .busy(busy8)
    );

    spi_master_tx #(.AXIS_DATA_WIDTH(16), .PRESCALE_WIDTH(PW)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(tdata16), .s_axis_tvalid(tvalid16), .s_axis_tready(tready16),
        .sclk(sclk16), .mosi(mosi16), .cs_n(cs_n16), .enable_capture(en16),
        .spi_mode(spi_mode), .spi_word_width(spi_word_width), .prescale(prescale),
        .busy(busy16)
    );

    wire m_sclk   = sel ? sclk16   : sclk8;
    wire m_mosi   = sel ? mosi16   : mosi8;
    wire m_cs_n   = sel ? cs_n16   : cs_n8;
    wire m_en     = sel ? en16     : en8;
    wire m_busy   = sel ? busy16   : busy8;
    wire m_tready = sel ? tready16 : tready8;
    wire cpol_b   = spi_mode[1];
    wire cpha_b   = spi_mode[0];

    typedef struct {
        logic [63:0] data;
        int          nbits;
        int          low;
    } frame_t;

    frame_t exp_q[$];
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- frame monitor ----------------
    logic        prev_sclk, prev_cs, prev_mosi;
    logic [63:0] rx;
    int          nbits, edges, low, high_cnt;
    logic        chk_gap = 1'b0;
    logic        is_edge, is_leading, is_sample;
    frame_t      mon_f;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_cs   = 1'b1;
            prev_sclk = m_sclk;
            prev_mosi = m_mosi;
            high_cnt  = 0;
        end else begin
            check("en_cap", m_en, !m_cs_n);
            is_edge    = (m_sclk !== prev_sclk);
            is_leading = (m_sclk !== cpol_b);
            is_sample  = is_edge && (is_leading != cpha_b);
            if (!m_cs_n) begin
                if (prev_cs) begin
                    if (chk_gap) begin
                        check("gap_high", high_cnt, 2);
                        chk_gap = 1'b0;
                    end
                    rx = '0; nbits = 0; edges = 0; low = 0;
                end else if (m_mosi !== prev_mosi) begin
                    check("mosi_on_drive_edge", is_edge && !is_sample, 1);
                end
                low++;
                check("busy", m_busy, 1);
                if (is_edge) edges++;
                if (is_sample) begin
                    rx = {rx[62:0], m_mosi};
                    nbits++;
                end
            end else begin
                if (!prev_cs) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        mon_f = exp_q.pop_front();
                        check("data", rx, mon_f.data);
                        check("nbits", nbits, mon_f.nbits);
                        check("edges", edges, 2 * mon_f.nbits);
                        check("cs_low_cycles", low, mon_f.low);
                        check("sclk_idle_end", m_sclk, cpol_b);
                    end
                    high_cnt = 0;
                end
                high_cnt++;
            end
            prev_cs   = m_cs_n;
            prev_sclk = m_sclk;
            prev_mosi = m_mosi;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [63:0] word, input int w_req, input int aw, input bit keep);
        int     w_eff;
        int     cyc;
        frame_t f;
        w_eff = (w_req == 0 || w_req > aw) ? aw : w_req;
        @(negedge clk);
        if (sel) begin tdata16 = word[15:0]; tvalid16 = 1'b1; end
        else     begin tdata8  = word[7:0];  tvalid8  = 1'b1; end
        cyc = 0;
        while (m_tready !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 2000) begin
            check("handshake_timeout", 0, 1);
            tvalid8 = 1'b0; tvalid16 = 1'b0;
            return;
        end
        f.data  = word & ((64'd1 << w_eff) - 64'd1);
        f.nbits = w_eff;
        f.low   = (int'(prescale) + 1) * (2 * w_eff + 2);
        exp_q.push_back(f);
        @(posedge clk);
        #1;
        if (!keep) begin tvalid8 = 1'b0; tvalid16 = 1'b0; end
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || m_tready !== 1'b1) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 5000) check("idle_timeout", 0, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; sel = 1'b0;
        tvalid8 = 1'b0; tvalid16 = 1'b0; tdata8 = '0; tdata16 = '0;
        spi_mode = 2'd0; spi_word_width = 6'd8; prescale = 16'd1;
        #12;
        check("rst_tready", tready8, 0);
        check("rst_cs_n",   cs_n8,   1);
        check("rst_sclk",   sclk8,   0);
        check("rst_mosi",   mosi8,   1);
        check("rst_en_cap", en8,     0);
        check("rst_busy",   busy8,   0);
        check("rst_tready16", tready16, 0);
        @(negedge clk); #2 rst_n = 1'b1;
        #1 check("tready_before_edge", tready8, 0);
        @(negedge clk);
        check("tready_after_reset", tready8, 1);

        // Mode 0, W=8, H=2
        send(64'hA5, 8, 8, 1'b0);
        wait_idle();

        // Mode 3, W=8, H=3
        spi_mode = 2'd3; prescale = 16'd2;
        repeat (3) @(negedge clk);
        check("cpol_idle_high", sclk8, 1);
        send(64'h3C, 8, 8, 1'b0);
        wait_idle();

        // Mode 1, W=12 on the 16-bit container, H=1
        sel = 1'b1; spi_mode = 2'd1; spi_word_width = 6'd12; prescale = 16'd0;
        repeat (2) @(negedge clk);
        send(64'h0ABC, 12, 16, 1'b0);
        wait_idle();
        sel = 1'b0;

        // Width clamp on the 8-bit container
        spi_mode = 2'd0; prescale = 16'd1; spi_word_width = 6'd0;
        repeat (2) @(negedge clk);
        send(64'hC3, 0, 8, 1'b0);
        wait_idle();
        spi_word_width = 6'd63;
        send(64'h5A, 63, 8, 1'b0);
        wait_idle();

        // Back-to-back with tvalid held, H=1
        spi_word_width = 6'd8; prescale = 16'd0;
        repeat (2) @(negedge clk);
        send(64'h01, 8, 8, 1'b1);
        @(negedge clk); #1 chk_gap = 1'b1;
        send(64'h80, 8, 8, 1'b0);
        wait_idle();
        check("gap_checked", chk_gap, 0);

        // Reset in the middle of a frame, H=4
        prescale = 16'd3;
        repeat (2) @(negedge clk);
        send(64'h55, 8, 8, 1'b0);
        repeat (26) @(negedge clk);
        check("mid_frame_cs_low", cs_n8, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cs_n",   cs_n8,   1);
        check("async_rst_mosi",   mosi8,   1);
        check("async_rst_sclk",   sclk8,   0);
        check("async_rst_en_cap", en8,     0);
        check("async_rst_tready", tready8, 0);
        @(negedge clk); #2 rst_n = 1'b1;
        #1 check("tready_low_after_release", tready8, 0);
        @(negedge clk);
        check("tready_one_cycle_after_release", tready8, 1);
        send(64'hFF, 8, 8, 1'b0);
        wait_idle();

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        check("global_timeout", 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
